// File: rtl/intc_pkg.sv
// Shared INTC types: error-capture FSM states and the source-count ceiling.
package intc_pkg;
  typedef enum logic [1:0] {ERR_IDLE, ERR_REQ, ERR_SRV} err_st_e;
  localparam int INTC_ERR_MAX_SRC = 32;
endpackage

// File: rtl/intc_err_capture_if.sv
// CPU-side request/acknowledge/end-of-interrupt handshake of the error capture unit.
// The master modport is the capture unit; the slave modport is the CPU.
interface intc_err_capture_if #(
  parameter int NUM_SRC = 8
) ();
  localparam int IDW = $clog2(NUM_SRC);

  logic           req_o;
  logic [IDW-1:0] req_id_o;
  logic           ack_i;
  logic           srv_o;
  logic [IDW-1:0] srv_id_o;
  logic           eoi_i;

  modport master (
    output req_o, req_id_o, srv_o, srv_id_o,
    input  ack_i, eoi_i
  );

  modport slave (
    input  req_o, req_id_o, srv_o, srv_id_o,
    output ack_i, eoi_i
  );
endinterface

// File: rtl/intc_err_capture_prio_enc.sv
// Combinational lowest-index-first priority encoder; zero latency, no backpressure.
module intc_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0]         i_in,
  output logic [$clog2(N)-1:0] o_id,
  output logic                 o_vld
);
  localparam int IDW = $clog2(N);

  always_comb begin
    o_id  = '0;
    o_vld = 1'b0;
    // Descending scan so the lowest set index is the last to write.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_in[i]) begin
        o_id  = IDW'(i);
        o_vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/intc_err_capture.sv
// Error-interrupt capture: edge/level pending + overflow, one lowest-index request via req/ack/eoi.
// Latency line->pend 1 cycle, pend->req 1 cycle; request is held until ack or withdrawn by clear/mask.
module intc_err_capture
  import intc_pkg::*;
#(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 0,
  parameter int AUTO_CLR    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] intreq_i,
  input  logic [NUM_SRC-1:0] rg_mode_i,
  input  logic [NUM_SRC-1:0] rg_mask_i,
  input  logic [NUM_SRC-1:0] rg_clr_i,
  output logic [NUM_SRC-1:0] pend_o,
  output logic [NUM_SRC-1:0] ovf_o,
  intc_err_capture_if.master cpu
);
  localparam int IDW = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0] w_s;
  logic [NUM_SRC-1:0] r_prev;
  logic [NUM_SRC-1:0] r_pend;
  logic [NUM_SRC-1:0] r_ovf;
  logic [NUM_SRC-1:0] w_set;
  logic [NUM_SRC-1:0] w_srv_bit;
  logic [NUM_SRC-1:0] w_eoi_clr;
  logic [NUM_SRC-1:0] w_pend_nxt;
  logic [NUM_SRC-1:0] w_ovf_nxt;
  logic [NUM_SRC-1:0] w_elig;
  logic               w_autoclr;
  logic [IDW-1:0]     w_win_id;
  logic               w_win_vld;

  err_st_e            r_st;
  logic               r_req;
  logic [IDW-1:0]     r_req_id;
  logic               r_srv;
  logic [IDW-1:0]     r_srv_id;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_s = intreq_i;
    end else begin : g_sync
      logic [NUM_SRC-1:0] r_sync [SYNC_STAGES];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
        end else begin
          r_sync[0] <= intreq_i;
          for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
        end
      end
      assign w_s = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  assign w_set     = (rg_mode_i & w_s) | (~rg_mode_i & w_s & ~r_prev);
  assign w_srv_bit = NUM_SRC'(1) << r_srv_id;
  assign w_autoclr = (AUTO_CLR != 0) && (r_st == ERR_SRV) && cpu.eoi_i;
  assign w_eoi_clr = w_srv_bit & {NUM_SRC{w_autoclr}};

  // Mask beats set beats clear; a fresh set survives an end-of-interrupt auto-clear.
  assign w_pend_nxt = ((r_pend & ~(rg_clr_i | w_eoi_clr)) | w_set) & ~rg_mask_i;
  assign w_ovf_nxt  = ((r_ovf & ~rg_clr_i) | (w_set & ~rg_mode_i & r_pend & ~rg_clr_i))
                      & ~rg_mask_i;

  assign w_elig = r_pend & ~rg_mask_i & ~(w_srv_bit & {NUM_SRC{r_srv}});

  intc_prio_enc #(.N(NUM_SRC)) u_prio (
    .i_in  (w_elig),
    .o_id  (w_win_id),
    .o_vld (w_win_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= '0;
      r_pend <= '0;
      r_ovf  <= '0;
    end else begin
      r_prev <= w_s;
      r_pend <= w_pend_nxt;
      r_ovf  <= w_ovf_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st     <= ERR_IDLE;
      r_req    <= 1'b0;
      r_req_id <= '0;
      r_srv    <= 1'b0;
      r_srv_id <= '0;
    end else begin
      case (r_st)
        ERR_IDLE: begin
          if (w_win_vld) begin
            r_st     <= ERR_REQ;
            r_req    <= 1'b1;
            r_req_id <= w_win_id;
          end
        end
        ERR_REQ: begin
          // Ack takes precedence over a same-cycle withdrawal.
          if (cpu.ack_i) begin
            r_st     <= ERR_SRV;
            r_req    <= 1'b0;
            r_srv    <= 1'b1;
            r_srv_id <= r_req_id;
          end else if (!w_pend_nxt[r_req_id]) begin
            r_st  <= ERR_IDLE;
            r_req <= 1'b0;
          end
        end
        ERR_SRV: begin
          if (cpu.eoi_i || rg_clr_i[r_srv_id] || rg_mask_i[r_srv_id]) begin
            r_st  <= ERR_IDLE;
            r_srv <= 1'b0;
          end
        end
        default: begin
          r_st  <= ERR_IDLE;
          r_req <= 1'b0;
          r_srv <= 1'b0;
        end
      endcase
    end
  end

  assign pend_o       = r_pend;
  assign ovf_o        = r_ovf;
  assign cpu.req_o    = r_req;
  assign cpu.req_id_o = r_req_id;
  assign cpu.srv_o    = r_srv;
  assign cpu.srv_id_o = r_srv_id;
endmodule

// File: tb/tb_intc_err_capture.sv
// Directed scenarios followed by randomized traffic, each cycle compared against a bit-level reference model.
module tb_intc_err_capture;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] intreq = '0;
  logic [7:0] mode = '0;
  logic [7:0] mask = '0;
  logic [7:0] clr = '0;
  logic       ack = 1'b0;
  logic       eoi = 1'b0;
  logic [7:0] pend_o;
  logic [7:0] ovf_o;

  int n_tests = 0;
  int n_fail = 0;

  // Reference model state: 0 = idle, 1 = requesting, 2 = in service.
  logic [7:0] m_pend, m_ovf, m_prev;
  int         m_st, m_req_id, m_srv_id;

  intc_err_capture_if #(.NUM_SRC(8)) cpu_if ();
  assign cpu_if.ack_i = ack;
  assign cpu_if.eoi_i = eoi;

  intc_err_capture #(.NUM_SRC(8), .SYNC_STAGES(0), .AUTO_CLR(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .intreq_i  (intreq),
    .rg_mode_i (mode),
    .rg_mask_i (mask),
    .rg_clr_i  (clr),
    .pend_o    (pend_o),
    .ovf_o     (ovf_o),
    .cpu       (cpu_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_ovf = '0; m_prev = '0;
    m_st = 0; m_req_id = 0; m_srv_id = 0;
  endtask

  task automatic model_step();
    logic [7:0] np, no;
    logic       setp, ac;
    int         win;
    np = m_pend;
    no = m_ovf;
    for (int i = 0; i < 8; i++) begin
      setp = mode[i] ? intreq[i] : (intreq[i] && !m_prev[i]);
      ac   = (m_st == 2) && eoi && (m_srv_id == i);
      if (mask[i]) begin
        np[i] = 1'b0;
        no[i] = 1'b0;
      end else begin
        if (setp) np[i] = 1'b1;
        else if (clr[i] || ac) np[i] = 1'b0;
        if (clr[i]) no[i] = 1'b0;
        else if (!mode[i] && setp && m_pend[i]) no[i] = 1'b1;
      end
    end
    case (m_st)
      0: begin
        win = -1;
        for (int i = 7; i >= 0; i--) if (m_pend[i] && !mask[i]) win = i;
        if (win >= 0) begin m_st = 1; m_req_id = win; end
      end
      1: begin
        if (ack) begin m_st = 2; m_srv_id = m_req_id; end
        else if (!np[m_req_id]) m_st = 0;
      end
      default: begin
        if (eoi || clr[m_srv_id] || mask[m_srv_id]) m_st = 0;
      end
    endcase
    m_prev = intreq;
    m_pend = np;
    m_ovf  = no;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pend"}, pend_o, m_pend);
    chk({tag, ".ovf"}, ovf_o, m_ovf);
    chk({tag, ".req"}, cpu_if.req_o, m_st == 1);
    chk({tag, ".srv"}, cpu_if.srv_o, m_st == 2);
    if (m_st == 1) chk({tag, ".req_id"}, cpu_if.req_id_o, m_req_id);
    if (m_st == 2) chk({tag, ".srv_id"}, cpu_if.srv_id_o, m_srv_id);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    intreq = '0; mode = '0; mask = '0; clr = '0; ack = 1'b0; eoi = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #7;
    rst_n = 1'b1;
    tick("rst");
  endtask

  task automatic chk_reset_zero(input string tag);
    chk({tag, ".pend0"}, pend_o, 0);
    chk({tag, ".ovf0"}, ovf_o, 0);
    chk({tag, ".req0"}, cpu_if.req_o, 0);
    chk({tag, ".req_id0"}, cpu_if.req_id_o, 0);
    chk({tag, ".srv0"}, cpu_if.srv_o, 0);
    chk({tag, ".srv_id0"}, cpu_if.srv_id_o, 0);
  endtask

  initial begin
    model_reset();
    #3;
    chk_reset_zero("init");
    do_reset();

    // Edge source 3: pend at +1, request at +2, service, eoi auto-clears.
    intreq[3] = 1'b1; tick("t1a");
    chk("t1.pend", pend_o, 8'h08);
    tick("t1b");
    chk("t1.req", cpu_if.req_o, 1);
    chk("t1.req_id", cpu_if.req_id_o, 3);
    ack = 1'b1; tick("t1c"); ack = 1'b0;
    chk("t1.srv", cpu_if.srv_o, 1);
    chk("t1.srv_id", cpu_if.srv_id_o, 3);
    eoi = 1'b1; tick("t1d"); eoi = 1'b0;
    chk("t1.pend_eoi", pend_o, 8'h00);
    tick("t1e");
    chk("t1.req_after", cpu_if.req_o, 0);

    // Simultaneous sources 1 and 5: lowest index first, then 5 two cycles after eoi.
    do_reset();
    intreq = 8'h22; tick("t2a"); tick("t2b");
    chk("t2.req_id1", cpu_if.req_id_o, 1);
    ack = 1'b1; tick("t2c"); ack = 1'b0;
    eoi = 1'b1; tick("t2d"); eoi = 1'b0;
    tick("t2e");
    chk("t2.req5", cpu_if.req_o, 1);
    chk("t2.req_id5", cpu_if.req_id_o, 5);

    // Overflow on a second edge while pending; clear; clear and edge together.
    do_reset();
    intreq[2] = 1'b1; tick("t3a");
    intreq[2] = 1'b0; tick("t3b");
    intreq[2] = 1'b1; tick("t3c");
    chk("t3.ovf", ovf_o, 8'h04);
    clr = 8'h04; tick("t3d"); clr = '0;
    chk("t3.pend_clr", pend_o[2], 0);
    chk("t3.ovf_clr", ovf_o, 8'h00);
    intreq[2] = 1'b0; tick("t3e");
    intreq[2] = 1'b1; clr = 8'h04; tick("t3f"); clr = '0;
    chk("t3.set_wins", pend_o[2], 1);

    // Level source 0: a clear is overridden while the line is high.
    do_reset();
    mode[0] = 1'b1; intreq[0] = 1'b1; tick("t4a");
    clr[0] = 1'b1; tick("t4b"); clr[0] = 1'b0;
    chk("t4.relevel", pend_o[0], 1);
    tick("t4c");
    intreq[0] = 1'b0; tick("t4d");
    clr[0] = 1'b1; tick("t4e"); clr[0] = 1'b0;
    tick("t4f");
    chk("t4.stays0", pend_o[0], 0);
    chk("t4.no_ovf", ovf_o[0], 0);

    // Withdrawal by mask before ack; a late ack is ignored.
    do_reset();
    intreq[4] = 1'b1; tick("t5a"); tick("t5b");
    chk("t5.req", cpu_if.req_o, 1);
    chk("t5.req_id", cpu_if.req_id_o, 4);
    mask[4] = 1'b1; tick("t5c");
    chk("t5.withdrawn", cpu_if.req_o, 0);
    chk("t5.pend4", pend_o[4], 0);
    ack = 1'b1; tick("t5d"); ack = 1'b0;
    chk("t5.late_ack", cpu_if.srv_o, 0);
    mask = '0;

    // Asynchronous reset in the middle of service.
    do_reset();
    intreq[6] = 1'b1; tick("t6a"); tick("t6b");
    ack = 1'b1; tick("t6c"); ack = 1'b0;
    chk("t6.in_srv", cpu_if.srv_o, 1);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_reset_zero("t6");
    intreq = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick("t6d"); tick("t6e");
    chk("t6.no_req", cpu_if.req_o, 0);

    // Randomized traffic with occasional mid-cycle resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      intreq = intreq ^ 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 49) == 0) mode = 8'($urandom);
      if ($urandom_range(0, 9) == 0) mask = 8'($urandom & $urandom & $urandom);
      clr = ($urandom_range(0, 3) == 0) ? 8'($urandom & $urandom & $urandom) : 8'h00;
      ack = ($urandom_range(0, 2) == 0);
      eoi = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_reset_zero("rnd_rst");
        #2 rst_n = 1'b1;
      end
      tick("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
